writeback_stage: RTL and testbench

//  MEM/WB pipeline register and writeback stage of the RV64 core, directly upstream of register_file.
//  - Latches one completed instruction from the memory stage.
//  - Selects and formats the result: ALU, load (aligned and sign/zero-extended), PC+4 or immediate.
//  - Drives the register_file write port (write_en/write_addr/write_data) and a forwarding port.
//  - Counts retired instructions.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/load_extender.sv | 41 ++++
 rtl/writeback_stage.sv | 122 ++++++++++++
 tb/tb_writeback_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared writeback-select and load funct3 encodings for the RV64 core.
// Rev    : 1.0
// ============================================================================
package riscv_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_IMM  = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage
`default_nettype wire

// File: rtl/load_extender.sv
`default_nettype none
// ============================================================================
// Module : load_extender
// Brief  : Selects the addressed lane of a loaded doubleword and extends it.
// Rev    : 1.0
// ============================================================================
module load_extender
  import riscv_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic [WORDSIZE-1:0] i_data,
  input  logic [2:0]          i_addr_lo,
  input  logic [2:0]          i_funct3,
  output logic [WORDSIZE-1:0] o_result
);

  logic [WORDSIZE-1:0] w_b_sh;
  logic [WORDSIZE-1:0] w_h_sh;
  logic [WORDSIZE-1:0] w_w_sh;

  // Lane selection drops the misaligned low bits for halfword and word loads.
  assign w_b_sh = i_data >> {i_addr_lo, 3'b000};
  assign w_h_sh = i_data >> {i_addr_lo[2:1], 4'b0000};
  assign w_w_sh = i_data >> {i_addr_lo[2], 5'b00000};

  always_comb begin
    o_result = i_data;
    case (i_funct3)
      F3_LB:   o_result = {{(WORDSIZE-8){w_b_sh[7]}}, w_b_sh[7:0]};
      F3_LH:   o_result = {{(WORDSIZE-16){w_h_sh[15]}}, w_h_sh[15:0]};
      F3_LW:   o_result = {{(WORDSIZE-32){w_w_sh[31]}}, w_w_sh[31:0]};
      F3_LBU:  o_result = {{(WORDSIZE-8){1'b0}}, w_b_sh[7:0]};
      F3_LHU:  o_result = {{(WORDSIZE-16){1'b0}}, w_h_sh[15:0]};
      F3_LWU:  o_result = {{(WORDSIZE-32){1'b0}}, w_w_sh[31:0]};
      default: o_result = i_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module : writeback_stage
// Brief  : MEM/WB pipeline register, result formatting, register-file write
//          port, forwarding port and retired-instruction counter.
// Rev    : 1.0
// ============================================================================
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_reg_write,
  input  logic [4:0]          in_rd,
  input  logic [1:0]          in_wb_sel,
  input  logic [2:0]          in_funct3,
  input  logic [2:0]          in_addr_lo,
  input  logic [WORDSIZE-1:0] in_alu_result,
  input  logic [WORDSIZE-1:0] in_load_data,
  input  logic [WORDSIZE-1:0] in_pc,
  input  logic [WORDSIZE-1:0] in_imm,
  input  logic                hold,
  input  logic                flush,
  output logic                write_en,
  output logic [4:0]          write_addr,
  output logic [WORDSIZE-1:0] write_data,
  output logic                fwd_valid,
  output logic [4:0]          fwd_addr,
  output logic [WORDSIZE-1:0] fwd_data,
  output logic [63:0]         instret
);

  logic                r_valid;
  logic                r_reg_write;
  logic [4:0]          r_rd;
  logic [1:0]          r_wb_sel;
  logic [2:0]          r_funct3;
  logic [2:0]          r_addr_lo;
  logic [WORDSIZE-1:0] r_alu;
  logic [WORDSIZE-1:0] r_load;
  logic [WORDSIZE-1:0] r_pc;
  logic [WORDSIZE-1:0] r_imm;
  logic [63:0]         r_instret;

  logic                w_accept;
  logic                w_retire;
  logic [WORDSIZE-1:0] w_load_res;
  logic [WORDSIZE-1:0] w_result;

  assign in_ready = !(hold && r_valid);
  assign w_accept = in_valid && in_ready && !flush;
  assign w_retire = r_valid && !hold && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_wb_sel    <= '0;
      r_funct3    <= '0;
      r_addr_lo   <= '0;
      r_alu       <= '0;
      r_load      <= '0;
      r_pc        <= '0;
      r_imm       <= '0;
      r_instret   <= '0;
    end else begin
      // flush outranks both accept and hold
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid     <= 1'b1;
        r_reg_write <= in_reg_write;
        r_rd        <= in_rd;
        r_wb_sel    <= in_wb_sel;
        r_funct3    <= in_funct3;
        r_addr_lo   <= in_addr_lo;
        r_alu       <= in_alu_result;
        r_load      <= in_load_data;
        r_pc        <= in_pc;
        r_imm       <= in_imm;
      end else if (!(hold && r_valid)) begin
        r_valid <= 1'b0;
      end
      if (w_retire) begin
        r_instret <= r_instret + 64'd1;
      end
    end
  end

  load_extender #(.WORDSIZE(WORDSIZE)) u_load_extender (
    .i_data    (r_load),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_funct3),
    .o_result  (w_load_res)
  );

  always_comb begin
    w_result = r_alu;
    case (r_wb_sel)
      WB_SEL_ALU:  w_result = r_alu;
      WB_SEL_LOAD: w_result = w_load_res;
      WB_SEL_PC4:  w_result = r_pc + WORDSIZE'(4);
      WB_SEL_IMM:  w_result = r_imm;
      default:     w_result = r_alu;
    endcase
  end

  assign write_en   = w_retire && r_reg_write && (r_rd != 5'd0);
  assign write_addr = r_rd;
  assign write_data = w_result;
  assign fwd_valid  = write_en;
  assign fwd_addr   = write_addr;
  assign fwd_data   = write_data;
  assign instret    = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_writeback_stage
// Brief  : Vector table, corner-case sequences and random traffic vs a model.
// Rev    : 1.0
// ============================================================================
module tb_writeback_stage;

  typedef struct {
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  wb_sel;
    logic [2:0]  f3;
    logic [2:0]  addr_lo;
    logic [63:0] alu;
    logic [63:0] ld;
    logic [63:0] pc;
    logic [63:0] imm;
    logic        exp_we;
    logic [63:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_reg_write, hold, flush;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3, in_addr_lo;
  logic [63:0] in_alu_result, in_load_data, in_pc, in_imm;
  logic        write_en, fwd_valid;
  logic [4:0]  write_addr, fwd_addr;
  logic [63:0] write_data, fwd_data, instret;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] e_instret;
  vec_t        vecs[12];

  always #5 clk = ~clk;

  writeback_stage #(.WORDSIZE(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result),
    .in_load_data(in_load_data), .in_pc(in_pc), .in_imm(in_imm),
    .hold(hold), .flush(flush), .write_en(write_en), .write_addr(write_addr),
    .write_data(write_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .instret(instret)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                              input logic [2:0] f3, input logic [2:0] lo, input logic [63:0] alu,
                              input logic [63:0] ld, input logic [63:0] pc, input logic [63:0] imm,
                              input logic we, input logic [63:0] data);
    vec_t v;
    v.reg_write = rw; v.rd = rd; v.wb_sel = sel; v.f3 = f3; v.addr_lo = lo;
    v.alu = alu; v.ld = ld; v.pc = pc; v.imm = imm; v.exp_we = we; v.exp_data = data;
    return v;
  endfunction

  // Reference result: extract nbytes at the naturally aligned lane, then extend.
  function automatic logic [63:0] ref_result(input vec_t v);
    int          nbytes;
    int          off;
    logic [63:0] val;
    logic [63:0] mask;
    case (v.wb_sel)
      2'd0: return v.alu;
      2'd2: return v.pc + 64'd4;
      2'd3: return v.imm;
      default: begin
        nbytes = 1 << v.f3[1:0];
        off    = (int'(v.addr_lo) / nbytes) * nbytes * 8;
        val    = v.ld >> off;
        if (nbytes < 8) begin
          mask = (64'd1 << (nbytes * 8)) - 64'd1;
          val  = val & mask;
          if (!v.f3[2] && val[nbytes*8-1]) val = val | ~mask;
        end
        return val;
      end
    endcase
  endfunction

  task automatic drive(input vec_t v);
    in_reg_write = v.reg_write; in_rd = v.rd; in_wb_sel = v.wb_sel;
    in_funct3 = v.f3; in_addr_lo = v.addr_lo; in_alu_result = v.alu;
    in_load_data = v.ld; in_pc = v.pc; in_imm = v.imm;
  endtask

  localparam logic [63:0] LD = 64'h8877_6655_4433_2211;

  vec_t m_inst;
  vec_t r_v;
  logic m_valid;
  logic [63:0] m_instret;
  logic exp_we, exp_rdy;

  initial begin
    vecs[0]  = mk(1, 5'd4,  2'd0, 3'b000, 3'd0, 64'd5,       LD, 64'h0, 64'h0, 1, 64'd5);
    vecs[1]  = mk(1, 5'd0,  2'd0, 3'b000, 3'd0, 64'hFFFF,    LD, 64'h0, 64'h0, 0, 64'hFFFF);
    vecs[2]  = mk(1, 5'd10, 2'd1, 3'b000, 3'd7, 64'h0,       LD, 64'h0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FF88);
    vecs[3]  = mk(1, 5'd11, 2'd1, 3'b101, 3'd2, 64'h0,       LD, 64'h0, 64'h0, 1, 64'h4433);
    vecs[4]  = mk(1, 5'd12, 2'd1, 3'b010, 3'd4, 64'h0,       LD, 64'h0, 64'h0, 1, 64'hFFFF_FFFF_8877_6655);
    vecs[5]  = mk(1, 5'd13, 2'd2, 3'b000, 3'd0, 64'h0,       LD, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1, 64'h0);
    vecs[6]  = mk(1, 5'd14, 2'd3, 3'b000, 3'd0, 64'h0,       LD, 64'h0, 64'h1234_5000, 1, 64'h1234_5000);
    vecs[7]  = mk(1, 5'd15, 2'd1, 3'b011, 3'd3, 64'h0,       LD, 64'h0, 64'h0, 1, LD);
    vecs[8]  = mk(1, 5'd16, 2'd1, 3'b110, 3'd5, 64'h0,       LD, 64'h0, 64'h0, 1, 64'h8877_6655);
    vecs[9]  = mk(1, 5'd17, 2'd1, 3'b001, 3'd7, 64'h0,       LD, 64'h0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_8877);
    vecs[10] = mk(1, 5'd31, 2'd1, 3'b100, 3'd0, 64'h0,       LD, 64'h0, 64'h0, 1, 64'h11);
    vecs[11] = mk(0, 5'd5,  2'd0, 3'b000, 3'd0, 64'hABCD,    LD, 64'h0, 64'h0, 0, 64'hABCD);

    rst_n = 1'b0; in_valid = 0; hold = 0; flush = 0;
    drive(vecs[0]);
    #12;
    chk("reset_write_en", 64'(write_en), 64'd0);
    chk("reset_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("reset_instret", instret, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    e_instret = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]); in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      @(negedge clk);
      chk($sformatf("vec%0d_write_en", i), 64'(write_en), 64'(vecs[i].exp_we));
      chk($sformatf("vec%0d_write_addr", i), 64'(write_addr), 64'(vecs[i].rd));
      chk($sformatf("vec%0d_write_data", i), write_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_fwd_data", i), fwd_data, vecs[i].exp_data);
      @(posedge clk); #1;
      e_instret++;
      chk($sformatf("vec%0d_instret", i), instret, e_instret);
    end

    // hold three cycles, then exactly one write
    drive(mk(1, 5'd7, 2'd0, 3'b000, 3'd0, 64'h77, LD, 64'h0, 64'h0, 1, 64'h77));
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; hold = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_write_en", 64'(write_en), 64'd0);
      chk("hold_instret", instret, e_instret);
      @(posedge clk); #1;
    end
    hold = 0;
    @(negedge clk);
    chk("release_write_en", 64'(write_en), 64'd1);
    chk("release_write_data", write_data, 64'h77);
    @(posedge clk); #1;
    e_instret++;
    chk("release_instret", instret, e_instret);
    @(negedge clk);
    chk("release_single_write", 64'(write_en), 64'd0);
    @(posedge clk); #1;

    // flush kills the held and the incoming instruction
    drive(mk(1, 5'd9, 2'd0, 3'b000, 3'd0, 64'h99, LD, 64'h0, 64'h0, 1, 64'h99));
    in_valid = 1;
    @(posedge clk); #1;
    in_rd = 5'd8; flush = 1; hold = 1;
    @(negedge clk);
    chk("flush_write_en", 64'(write_en), 64'd0);
    @(posedge clk); #1;
    flush = 0; hold = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_next_write_en", 64'(write_en), 64'd0);
    chk("flush_instret", instret, e_instret);
    @(posedge clk); #1;
    chk("flush_after_instret", instret, e_instret);

    // asynchronous reset mid-instruction
    drive(mk(1, 5'd3, 2'd0, 3'b000, 3'd0, 64'h1, LD, 64'h0, 64'h0, 1, 64'h1));
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    chk("pre_reset_write_en", 64'(write_en), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("async_reset_write_en", 64'(write_en), 64'd0);
    chk("async_reset_instret", instret, 64'd0);
    @(negedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    // random traffic against the model
    m_valid = 0; m_instret = 0; m_inst = vecs[0];
    for (int n = 0; n < 1500; n++) begin
      r_v = mk($urandom_range(0, 3) != 0, 5'($urandom), 2'($urandom), 3'($urandom), 3'($urandom),
               {$urandom, $urandom}, {$urandom, $urandom},
               (n % 50 == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom},
               {$urandom, $urandom}, 0, 0);
      drive(r_v);
      in_valid = $urandom_range(0, 9) < 7;
      hold     = $urandom_range(0, 99) < 15;
      flush    = $urandom_range(0, 99) < 5;
      exp_rdy  = !(hold && m_valid);
      exp_we   = m_valid && !hold && !flush && m_inst.reg_write && (m_inst.rd != 5'd0);
      @(negedge clk);
      chk("rnd_in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("rnd_write_en", 64'(write_en), 64'(exp_we));
      chk("rnd_fwd_valid", 64'(fwd_valid), 64'(exp_we));
      chk("rnd_instret", instret, m_instret);
      if (m_valid) begin
        chk("rnd_write_addr", 64'(write_addr), 64'(m_inst.rd));
        chk("rnd_write_data", write_data, ref_result(m_inst));
        chk("rnd_fwd_addr", 64'(fwd_addr), 64'(m_inst.rd));
      end
      @(posedge clk);
      if (m_valid && !hold && !flush) m_instret = m_instret + 64'd1;
      if (flush) m_valid = 0;
      else if (in_valid && exp_rdy) begin m_valid = 1; m_inst = r_v; end
      else if (!(hold && m_valid)) m_valid = 0;
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
